// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED pattern sequencer.
//   mode_e   - CTRL.mode encoding (OFF / SEQ / ROTL / ROTR)
//   state_e  - sequencer FSM state, visible in STATUS[3:2]
//   ADDR_*   - register select values on the bus
//   CTRL_* / STATUS_* - bit positions inside CTRL and STATUS
//   rotl4 / rotr4 - one-position rotations of a 4-bit LED value
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SEQ  = 2'd1,
    MODE_ROTL = 2'd2,
    MODE_ROTR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_PATTERN = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int unsigned CTRL_MODE_LSB    = 32'd0;
  localparam int unsigned CTRL_ONESHOT_BIT = 32'd2;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 32'd3;
  localparam int unsigned CTRL_LEN_LSB     = 32'd4;
  localparam int unsigned CTRL_W           = 32'd7;

  localparam int unsigned STATUS_DONE_BIT  = 32'd0;
  localparam int unsigned STATUS_DROP_BIT  = 32'd1;

  function automatic logic [3:0] rotl4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic logic [3:0] rotr4(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// led_sequencer_if: register bus between the bus bridge and the sequencer.
//   addr - register select (CTRL, PERIOD, PATTERN, STATUS)
//   we   - write strobe
//   din  - write data
//   dout - combinational read data for addr
// master = bus bridge side, slave = sequencer side.
interface led_sequencer_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output addr, output we, output din, input dout);
  modport slave  (input addr, input we, input din, output dout);
endinterface

// File: rtl/led_seq_prescaler.sv
// led_seq_prescaler: CNT_W-bit down-counter timing the sequencer steps.
//   clk, rst_n - clock and synchronous active-low reset
//   load       - load load_val (has priority over dec)
//   load_val   - reload value (PERIOD)
//   dec        - decrement by one
//   zero       - count is zero
module led_seq_prescaler #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Down-counter with load priority; never decremented past zero by the caller.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  // Zero flag drives the step decision in the same cycle.
  always_comb begin
    zero = (count_r == {CNT_W{1'b0}});
  end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: autonomous pattern controller for the 4-bit LED device.
//   clk, rst_n   - clock and synchronous active-low reset
//   bus          - register bus (slave side): CTRL, PERIOD, PATTERN, STATUS
//   cpu_led_we   - direct CPU write request to the LED device
//   cpu_led_din  - data for the direct CPU write
//   led_q        - current LED device value
//   led_we       - LED device write enable
//   led_din      - LED device write data
//   irq          - level interrupt, STATUS.done & CTRL.irq_en
// The step decision is made in any START/RUN cycle whose counter is zero and
// is registered, so a step pulse appears in the cycle after that decision.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_sequencer_if.slave       bus,
  input  logic                 cpu_led_we,
  input  logic [3:0]           cpu_led_din,
  input  logic [3:0]           led_q,
  output logic                 led_we,
  output logic [3:0]           led_din,
  output logic                 irq
);

  logic [CTRL_W-1:0] ctrl_r;
  logic [CNT_W-1:0]  period_r;
  logic [31:0]       pattern_r;
  logic              done_r;
  logic              drop_r;
  state_e            state_r;
  logic [2:0]        idx_r;
  logic [3:0]        rot_r;
  logic              led_we_r;
  logic [3:0]        led_din_r;

  mode_e             mode_s;
  logic              ctrl_wr_s;
  logic              status_wr_s;
  logic              start_s;
  logic              active_s;
  logic              cnt_zero_s;
  logic              step_due_s;
  logic [2:0]        last_idx_s;
  logic              at_last_s;
  logic              finish_s;
  logic              emit_s;
  logic [2:0]        next_idx_s;
  logic [3:0]        next_val_s;
  logic              cnt_load_s;
  logic              cnt_dec_s;

  led_seq_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load_s),
    .load_val (period_r),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Step control: a CTRL write always wins over a due step.
  always_comb begin
    mode_s      = mode_e'(ctrl_r[CTRL_MODE_LSB +: 2]);
    ctrl_wr_s   = bus.we && (bus.addr == ADDR_CTRL);
    status_wr_s = bus.we && (bus.addr == ADDR_STATUS);
    start_s     = ctrl_wr_s && (bus.din[1:0] != 2'd0);
    active_s    = (state_r == ST_START) || (state_r == ST_RUN);
    step_due_s  = active_s && cnt_zero_s && !ctrl_wr_s;
    if (mode_s == MODE_SEQ) begin
      last_idx_s = ctrl_r[CTRL_LEN_LSB +: 3];
    end else begin
      last_idx_s = 3'd3;
    end
    at_last_s  = (idx_r == last_idx_s);
    finish_s   = step_due_s && ctrl_r[CTRL_ONESHOT_BIT] && at_last_s;
    emit_s     = step_due_s && !finish_s;
    next_idx_s = at_last_s ? 3'd0 : (idx_r + 3'd1);
    case (mode_s)
      MODE_SEQ:  next_val_s = pattern_r[{next_idx_s, 2'b00} +: 4];
      MODE_ROTL: next_val_s = rotl4(rot_r);
      MODE_ROTR: next_val_s = rotr4(rot_r);
      default:   next_val_s = 4'd0;
    endcase
    cnt_load_s = start_s || emit_s;
    cnt_dec_s  = active_s && !cnt_zero_s;
  end

  // Configuration registers; STATUS bits are owned by the FSM block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_r    <= {CTRL_W{1'b0}};
      period_r  <= {CNT_W{1'b0}};
      pattern_r <= 32'd0;
    end else if (bus.we) begin
      case (bus.addr)
        ADDR_CTRL:    ctrl_r    <= bus.din[CTRL_W-1:0];
        ADDR_PERIOD:  period_r  <= CNT_W'(bus.din);
        ADDR_PATTERN: pattern_r <= bus.din;
        default:      pattern_r <= pattern_r;
      endcase
    end else begin
      ctrl_r <= ctrl_r;
    end
  end

  // Sequencer FSM with registered LED write port and sticky status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      idx_r     <= 3'd0;
      rot_r     <= 4'd0;
      led_we_r  <= 1'b0;
      led_din_r <= 4'd0;
      done_r    <= 1'b0;
      drop_r    <= 1'b0;
    end else begin
      led_we_r <= 1'b0;
      if (ctrl_wr_s) begin
        if (start_s) begin
          // Step 0 is PATTERN[3:0] for every mode; it also seeds the rotation.
          state_r   <= ST_START;
          idx_r     <= 3'd0;
          rot_r     <= pattern_r[3:0];
          led_we_r  <= 1'b1;
          led_din_r <= pattern_r[3:0];
        end else begin
          state_r <= ST_IDLE;
        end
      end else begin
        case (state_r)
          ST_START, ST_RUN: begin
            if (finish_s) begin
              state_r <= ST_DONE;
            end else if (emit_s) begin
              state_r   <= ST_RUN;
              idx_r     <= next_idx_s;
              rot_r     <= next_val_s;
              led_we_r  <= 1'b1;
              led_din_r <= next_val_s;
            end else begin
              state_r <= ST_RUN;
            end
          end
          ST_IDLE: state_r <= ST_IDLE;
          ST_DONE: state_r <= ST_DONE;
          default: state_r <= ST_IDLE;
        endcase
      end

      // Set has priority over a same-cycle clear.
      if (finish_s) begin
        done_r <= 1'b1;
      end else if (status_wr_s && bus.din[STATUS_DONE_BIT]) begin
        done_r <= 1'b0;
      end else begin
        done_r <= done_r;
      end

      if (active_s && cpu_led_we) begin
        drop_r <= 1'b1;
      end else if (status_wr_s && bus.din[STATUS_DROP_BIT]) begin
        drop_r <= 1'b0;
      end else begin
        drop_r <= drop_r;
      end
    end
  end

  // Register read mux.
  always_comb begin
    case (bus.addr)
      ADDR_CTRL:    bus.dout = {{(32-CTRL_W){1'b0}}, ctrl_r};
      ADDR_PERIOD:  bus.dout = 32'(period_r);
      ADDR_PATTERN: bus.dout = pattern_r;
      ADDR_STATUS:  bus.dout = {24'd0, led_q, state_r, drop_r, done_r};
      default:      bus.dout = 32'd0;
    endcase
  end

  // LED port arbitration: controller owns the port only in START/RUN.
  always_comb begin
    if (active_s) begin
      led_we  = led_we_r;
      led_din = led_din_r;
    end else begin
      led_we  = cpu_led_we;
      led_din = cpu_led_din;
    end
    irq = done_r & ctrl_r[CTRL_IRQ_EN_BIT];
  end

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed self-checking bench for led_sequencer.
// A tiny LED device model latches led_din on led_we so STATUS[7:4] can be checked.
module tb_led_sequencer;
  import led_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_led_we = 1'b0;
  logic [3:0] cpu_led_din = 4'd0;
  logic [3:0] led_q;
  logic       led_we;
  logic [3:0] led_din;
  logic       irq;

  int checks = 0;
  int errors = 0;

  logic [3:0] seq_vals  [4];
  logic [3:0] rotl_vals [4];
  logic [3:0] rotr_vals [4];

  led_sequencer_if bus_if ();

  led_sequencer #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .cpu_led_we  (cpu_led_we),
    .cpu_led_din (cpu_led_din),
    .led_q       (led_q),
    .led_we      (led_we),
    .led_din     (led_din),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // LED output device model.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q <= 4'd0;
    end else if (led_we) begin
      led_q <= led_din;
    end else begin
      led_q <= led_q;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.addr = a;
    bus_if.din  = d;
    bus_if.we   = 1'b1;
    tick();
    bus_if.we   = 1'b0;
  endtask

  task automatic reg_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus_if.addr = a;
    #1;
    check_val(tag, bus_if.dout, exp);
  endtask

  // Checks ncyc cycles starting at a step-0 cycle: a pulse every per+1 cycles.
  task automatic check_stream(input string tag, input int ncyc, input int per,
                              input logic [3:0] vals [4]);
    int step;
    step = 0;
    for (int k = 0; k < ncyc; k++) begin
      if ((k % (per + 1)) == 0) begin
        check_val({tag, "_we"}, 32'(led_we), 32'd1);
        check_val({tag, "_din"}, 32'(led_din), 32'(vals[step % 4]));
        step++;
      end else begin
        check_val({tag, "_gap"}, 32'(led_we), 32'd0);
      end
      tick();
    end
  endtask

  task automatic check_quiet(input string tag, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      check_val(tag, 32'(led_we), 32'd0);
      tick();
    end
  endtask

  initial begin
    seq_vals  = '{4'h1, 4'h2, 4'h3, 4'h4};
    rotl_vals = '{4'h1, 4'h2, 4'h4, 4'h8};
    rotr_vals = '{4'h1, 4'h8, 4'h4, 4'h2};
    bus_if.addr = 2'd0;
    bus_if.we   = 1'b0;
    bus_if.din  = 32'd0;

    // Reset state.
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_val("rst_led_we", 32'(led_we), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    reg_check("rst_ctrl", ADDR_CTRL, 32'd0);
    reg_check("rst_period", ADDR_PERIOD, 32'd0);
    reg_check("rst_pattern", ADDR_PATTERN, 32'd0);
    reg_check("rst_status", ADDR_STATUS, 32'd0);

    // Passthrough in IDLE.
    tick();
    cpu_led_we  = 1'b1;
    cpu_led_din = 4'hA;
    #1;
    check_val("pass_we", 32'(led_we), 32'd1);
    check_val("pass_din", 32'(led_din), 32'hA);
    tick();
    cpu_led_we = 1'b0;
    reg_check("pass_status", ADDR_STATUS, 32'h0000_00A0);

    // SEQ continuous, PERIOD 2, len 3.
    reg_write(ADDR_PATTERN, 32'h0000_4321);
    reg_write(ADDR_PERIOD, 32'd2);
    reg_write(ADDR_CTRL, 32'h0000_0031);
    reg_check("seq_state_start", ADDR_STATUS, 32'h0000_00A4);
    check_stream("seq", 13, 2, seq_vals);
    // Offset 13: mid-gap. Offset 14 is a step-decision cycle; rewrite CTRL there.
    reg_check("seq_state_run", ADDR_STATUS, 32'h0000_0018);
    tick();
    reg_write(ADDR_CTRL, 32'h0000_0031);
    reg_check("restart_state", ADDR_STATUS, 32'h0000_0014);
    check_stream("restart", 7, 2, seq_vals);

    // CPU write during RUN is dropped; stream continues.
    cpu_led_we  = 1'b1;
    cpu_led_din = 4'hA;
    #1;
    check_val("drop_we", 32'(led_we), 32'd0);
    check_val("drop_din", 32'(led_din), 32'h3);
    tick();
    cpu_led_we = 1'b0;
    tick();
    check_val("drop_next_we", 32'(led_we), 32'd1);
    check_val("drop_next_din", 32'(led_din), 32'h4);
    reg_check("drop_status", ADDR_STATUS, 32'h0000_003A);
    reg_write(ADDR_STATUS, 32'h0000_0002);
    reg_check("drop_clear", ADDR_STATUS, 32'h0000_0048);

    // Mode OFF returns to IDLE with no further pulses.
    reg_write(ADDR_CTRL, 32'h0000_0000);
    reg_check("off_state", ADDR_STATUS, 32'h0000_0040);
    check_quiet("off_quiet", 6);

    // ROTL oneshot with irq, PERIOD 0.
    reg_write(ADDR_PATTERN, 32'h0000_0001);
    reg_write(ADDR_PERIOD, 32'd0);
    reg_write(ADDR_CTRL, 32'h0000_000E);
    check_val("rotl_irq_pre", 32'(irq), 32'd0);
    check_stream("rotl", 4, 0, rotl_vals);
    check_val("rotl_irq", 32'(irq), 32'd1);
    check_val("rotl_done_we", 32'(led_we), 32'd0);
    reg_check("rotl_status", ADDR_STATUS, 32'h0000_008D);
    check_quiet("done_quiet", 3);

    // Passthrough in DONE.
    cpu_led_we  = 1'b1;
    cpu_led_din = 4'h5;
    #1;
    check_val("done_pass_we", 32'(led_we), 32'd1);
    check_val("done_pass_din", 32'(led_din), 32'h5);
    tick();
    cpu_led_we = 1'b0;
    reg_check("done_led_q", ADDR_STATUS, 32'h0000_005D);
    reg_write(ADDR_STATUS, 32'h0000_0001);
    check_val("irq_clear", 32'(irq), 32'd0);
    reg_check("done_clear", ADDR_STATUS, 32'h0000_005C);

    // ROTR continuous, PERIOD 0, wraps after 4 steps.
    reg_write(ADDR_CTRL, 32'h0000_0003);
    check_stream("rotr", 6, 0, rotr_vals);
    reg_write(ADDR_CTRL, 32'h0000_0000);
    check_quiet("rotr_off", 3);

    // Reset during RUN with PERIOD 5.
    reg_write(ADDR_PATTERN, 32'h0000_4321);
    reg_write(ADDR_PERIOD, 32'd5);
    reg_write(ADDR_CTRL, 32'h0000_0031);
    check_stream("pre_rst", 3, 5, seq_vals);
    rst_n = 1'b0;
    tick();
    check_val("mid_rst_we", 32'(led_we), 32'd0);
    rst_n = 1'b1;
    reg_check("mid_rst_ctrl", ADDR_CTRL, 32'd0);
    reg_check("mid_rst_period", ADDR_PERIOD, 32'd0);
    reg_check("mid_rst_pattern", ADDR_PATTERN, 32'd0);
    reg_check("mid_rst_status", ADDR_STATUS, 32'd0);
    tick();
    check_quiet("post_rst_quiet", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Autonomous pattern controller for the 4-bit LED output device. It sits between the bus bridge and the LED device. It holds CTRL, PERIOD, PATTERN and STATUS registers and drives the LED device's write port with timed step patterns. It also arbitrates that write port between itself and direct CPU LED writes.

## Interface
- `CNT_W`, default 32: width of PERIOD and the prescaler counter.

Ports (name, direction, width, meaning):
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `addr`, in, 2: register select. 0 = CTRL, 1 = PERIOD, 2 = PATTERN, 3 = STATUS.
- `we`, in, 1: register write strobe.
- `din`, in, 32: register write data.
- `dout`, out, 32: combinational read data for `addr`.
- `cpu_led_we`, in, 1: direct CPU write request to the LED device.
- `cpu_led_din`, in, 4: data for the direct CPU write.
- `led_q`, in, 4: current LED device value (the device's `Dout[3:0]`).
- `led_we`, out, 1: LED device write enable.
- `led_din`, out, 4: LED device write data.
- `irq`, out, 1: level interrupt, equal to `STATUS.done & CTRL.irq_en`.

## Operation
Registers (all reset to 0):
- CTRL:
  - [1:0] mode: 0 OFF, 1 SEQ, 2 ROTL, 3 ROTR.
  - [2] oneshot.
  - [3] irq_en.
  - [6:4] len; SEQ step count is N = len+1.
  - Other bits read 0.
- PERIOD: [CNT_W-1:0]. A step is emitted every PERIOD+1 cycles.
- PATTERN: [31:0]. Step k of SEQ is `PATTERN[4k+3:4k]`.
- STATUS:
  - [0] done, sticky.
  - [1] drop, sticky.
  - [3:2] FSM state.
  - [7:4] `led_q`.
  - Writing STATUS with a 1 in bit 0 clears done; a 1 in bit 1 clears drop. Other STATUS bits are read-only.

States and transitions:
- IDLE → START on any CTRL write with mode ≠ 0.
- START (one cycle):
  - Asserts `led_we` with the step-0 value.
  - Sets idx to 0.
  - Loads the counter with PERIOD.
  - For ROTL/ROTR, loads the rotation register with `PATTERN[3:0]`.
  - Goes to RUN.
- RUN, counter ≠ 0: decrement the counter.
- RUN, counter = 0:
  - If oneshot and idx = last step → DONE and set done. `led_we` is not asserted.
  - Otherwise: idx+1 (wrap to 0 after the last step), assert `led_we` with the next value, reload the counter with PERIOD.
- DONE: holds and emits nothing.
- Any CTRL write restarts the sequence: mode ≠ 0 → START, mode = 0 → IDLE. This applies from every state, including mid-RUN.

Step values and step counts:
- SEQ: `PATTERN` nibble idx, read live at each step; last step is N−1.
- ROTL/ROTR: the rotation register rotated by 1 in the given direction at each step. The seed is taken only at START. The last step is index 3 (4 steps).

Register update rules:
- A PERIOD write takes effect at the next counter reload.
- A PATTERN write affects SEQ at its next step; it does not affect ROT until the next START.

Arbitration:
- In IDLE or DONE: `led_we = cpu_led_we` and `led_din = cpu_led_din`.
- In START or RUN, the controller owns the port. An asserted `cpu_led_we` is discarded and sets drop.

## Timing
- Reset values: `led_we` = 0, `led_din` = 0, `irq` = 0, state IDLE, all registers 0. `rst_n` low mid-run forces IDLE at the next edge. `led_we` is 0 in the cycle after reset.
- A CTRL write at edge t gives START (first `led_we` pulse) in cycle t+1. Subsequent pulses follow every PERIOD+1 cycles; PERIOD = 0 gives a pulse every cycle.
- `led_we` / `led_din` are registered in controller states. In IDLE/DONE they are a combinational passthrough of the CPU write.
- Oneshot completion: done and `irq` assert PERIOD+1 cycles after the last step's pulse.
- Simultaneous events:
  - A CTRL write in a step-emission cycle: the write wins, the step is suppressed, and START follows.
  - A done set and a STATUS clear in the same cycle: the set wins.
  - A drop set and a clear in the same cycle: the set wins.
- The counter is CNT_W bits. PERIOD = 2^CNT_W−1 is legal and needs no overflow handling.

## Structure
- Package `led_seq_pkg` holds:
  - the mode enum (OFF/SEQ/ROTL/ROTR);
  - the state enum (IDLE=0, START=1, RUN=2, DONE=3);
  - register offset constants;
  - CTRL/STATUS bit-position constants.
- One sub-module: `led_seq_prescaler`, a CNT_W down-counter with a load input and a zero flag.
- The FSM, registers and arbitration mux live in `led_sequencer`.

## Test plan
- Reset → `led_we` = 0, `irq` = 0, all reads 0. Passthrough: `cpu_led_we` = 1 with `cpu_led_din` = 4'hA → `led_we` = 1 and `led_din` = 4'hA in the same cycle.
- PATTERN = 32'h0000_4321, PERIOD = 2, CTRL = mode SEQ, len = 3, continuous → `led_din` 1, 2, 3, 4, 1, … with pulses 3 cycles apart, the first in the cycle after the write.
- PATTERN[3:0] = 4'b0001, PERIOD = 0, ROTL, oneshot, irq_en → pulses 1, 2, 4, 8 on consecutive cycles. done and `irq` go high one cycle after the 8. Writing STATUS = 1 clears `irq`.
- `cpu_led_we` pulse during RUN → no change to the LED write stream, and STATUS[1] = 1. In DONE, a CPU write of 4'h5 passes through.
- CTRL rewrite mid-RUN on a step cycle → that step is suppressed, the next cycle emits step 0, and idx restarts. CTRL = mode OFF → IDLE, with no further pulses.
- `rst_n` low for one edge during RUN with PERIOD = 5 → IDLE, `led_we` = 0, registers cleared, no pulses afterwards.
